// File: rtl/pwm_leds_bus_interface_if.sv
// Bus bundle for the LED controller: address, request strobes, byte masks,
// a shared bidirectional data bus and the function-complete line.
// The tristate buffers for data_bus and fc_bus live here, so every driver
// of the shared nets is resolved in one place. The master and the slave
// only provide a value and an output enable for their side.
interface pwm_leds_bus_interface_if;
   logic [31:0] addr_bus;
   wire  [31:0] data_bus;
   logic        rd_bus;
   logic        wr_bus;
   logic [3:0]  data_mask_bus;
   wire         fc_bus;

   logic [31:0] mstData;
   logic        mstOe;

   logic [31:0] slvData;
   logic        slvDataOe;
   logic        slvFcOe;

   assign data_bus = mstOe     ? mstData : 32'bz;
   assign data_bus = slvDataOe ? slvData : 32'bz;
   assign fc_bus   = slvFcOe   ? 1'b1    : 1'bz;

   modport slave (
      input  addr_bus, data_bus, rd_bus, wr_bus, data_mask_bus,
      output slvData, slvDataOe, slvFcOe
   );

   modport master (
      output addr_bus, rd_bus, wr_bus, data_mask_bus, mstData, mstOe,
      input  data_bus, fc_bus
   );
endinterface

// File: rtl/pwm_leds_bus_interface.sv
// Memory-mapped LED controller. It provides on/off control per LED, PWM
// brightness per LED with period-aligned duty updates, and a global blink
// mode whose half-period is counted in PWM periods.
module pwm_leds_bus_interface #(
   parameter int          LED_COUNT       = 8,
   parameter int          PWM_WIDTH       = 8,
   parameter logic [31:0] CTRL_REG_ADDR   = 32'h7000_0000,
   parameter logic [31:0] STATUS_REG_ADDR = 32'h7000_0004,
   parameter logic [31:0] DATA_REG_ADDR   = 32'h7000_0008,
   parameter logic [31:0] BLINK_REG_ADDR  = 32'h7000_000C,
   parameter logic [31:0] DUTY_REG_BASE   = 32'h7000_0010
) (
   input  logic                        clk,
   input  logic                        rst,
   pwm_leds_bus_interface_if.slave     bus,
   output logic                        ctrl_en,
   output logic [LED_COUNT-1:0]        ctrl_leds
);

   typedef enum logic {IDLE, ACK} busState_t;

   busState_t            r_state;
   logic                 r_ack;
   logic                 r_rdAck;
   logic [31:0]          r_rdData;

   logic [2:0]           r_ctrl;
   logic [LED_COUNT-1:0] r_data;
   logic [15:0]          r_blinkP;
   logic [PWM_WIDTH-1:0] r_dutyShadow [LED_COUNT];
   logic [PWM_WIDTH-1:0] r_dutyActive [LED_COUNT];

   logic [PWM_WIDTH-1:0] r_pwmCnt;
   logic [15:0]          r_blinkCnt;
   logic                 r_phase;
   logic [LED_COUNT-1:0] r_leds;

   logic                 w_hitCtrl;
   logic                 w_hitStatus;
   logic                 w_hitData;
   logic                 w_hitBlink;
   logic [LED_COUNT-1:0] w_dutySel;
   logic                 w_hit;
   logic                 w_oneReq;
   logic [31:0]          w_mask32;
   logic [31:0]          w_rdValue;
   logic                 w_pwmWrap;
   logic                 w_blinkEnd;

   // Byte-lane merge: lanes with their mask bit clear keep the old contents.
   function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                              input logic [31:0] newVal,
                                              input logic [31:0] mask);
      return (oldVal & ~mask) | (newVal & mask);
   endfunction

   assign w_hitCtrl   = (bus.addr_bus == CTRL_REG_ADDR);
   assign w_hitStatus = (bus.addr_bus == STATUS_REG_ADDR);
   assign w_hitData   = (bus.addr_bus == DATA_REG_ADDR);
   assign w_hitBlink  = (bus.addr_bus == BLINK_REG_ADDR);
   assign w_hit       = w_hitCtrl | w_hitStatus | w_hitData | w_hitBlink | (|w_dutySel);
   assign w_oneReq    = bus.rd_bus ^ bus.wr_bus;
   assign w_mask32    = {{8{bus.data_mask_bus[3]}}, {8{bus.data_mask_bus[2]}},
                         {8{bus.data_mask_bus[1]}}, {8{bus.data_mask_bus[0]}}};
   assign w_pwmWrap   = &r_pwmCnt;
   assign w_blinkEnd  = (r_blinkCnt == r_blinkP - 16'd1);

   assign bus.slvData   = r_rdData;
   assign bus.slvDataOe = r_rdAck;
   assign bus.slvFcOe   = r_ack;
   assign ctrl_en       = r_ctrl[0];
   assign ctrl_leds     = r_leds;

   // One-hot decode of the per-LED duty registers; only existing LEDs decode.
   always_comb begin
      for (int i = 0; i < LED_COUNT; i++) begin
         w_dutySel[i] = (bus.addr_bus == DUTY_REG_BASE + 32'(4 * i));
      end
   end

   // Read mux: current register contents, zero-extended to the bus width.
   always_comb begin
      w_rdValue = 32'd0;
      if (w_hitCtrl)   w_rdValue = 32'(r_ctrl);
      if (w_hitStatus) w_rdValue = {30'd0, r_phase, r_ctrl[0]};
      if (w_hitData)   w_rdValue = 32'(r_data);
      if (w_hitBlink)  w_rdValue = 32'(r_blinkP);
      for (int i = 0; i < LED_COUNT; i++) begin
         if (w_dutySel[i]) w_rdValue = 32'(r_dutyShadow[i]);
      end
   end

   // Bus FSM: takes one access per request, then holds the acknowledge until
   // both strobes drop so that a long request cannot repeat the access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ack    <= 1'b0;
         r_rdAck  <= 1'b0;
         r_rdData <= 32'd0;
         r_ctrl   <= 3'd0;
         r_data   <= '0;
         r_blinkP <= 16'd0;
         for (int i = 0; i < LED_COUNT; i++) r_dutyShadow[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hit && w_oneReq) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
                  if (bus.wr_bus) begin
                     r_rdAck <= 1'b0;
                     if (w_hitCtrl)
                        r_ctrl <= 3'(mergeBytes(32'(r_ctrl), bus.data_bus, w_mask32));
                     if (w_hitData)
                        r_data <= LED_COUNT'(mergeBytes(32'(r_data), bus.data_bus, w_mask32));
                     if (w_hitBlink)
                        r_blinkP <= 16'(mergeBytes(32'(r_blinkP), bus.data_bus, w_mask32));
                     for (int i = 0; i < LED_COUNT; i++) begin
                        if (w_dutySel[i])
                           r_dutyShadow[i] <= PWM_WIDTH'(mergeBytes(32'(r_dutyShadow[i]),
                                                                    bus.data_bus, w_mask32));
                     end
                  end else begin
                     r_rdAck  <= 1'b1;
                     r_rdData <= w_rdValue;
                  end
               end
            end
            ACK: begin
               if (!bus.rd_bus && !bus.wr_bus) begin
                  r_state <= IDLE;
                  r_ack   <= 1'b0;
                  r_rdAck <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // PWM counter, period-aligned duty loading, blink phase and LED drive.
   // While disabled, everything parks and the active duties track the
   // shadows, so enabling starts cleanly on the latest written duties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwmCnt   <= '0;
         r_blinkCnt <= 16'd0;
         r_phase    <= 1'b1;
         r_leds     <= '0;
         for (int i = 0; i < LED_COUNT; i++) r_dutyActive[i] <= '0;
      end else if (!r_ctrl[0]) begin
         r_pwmCnt   <= '0;
         r_blinkCnt <= 16'd0;
         r_phase    <= 1'b1;
         r_leds     <= '0;
         for (int i = 0; i < LED_COUNT; i++) r_dutyActive[i] <= r_dutyShadow[i];
      end else begin
         r_pwmCnt <= r_pwmCnt + 1'b1;
         if (w_pwmWrap) begin
            for (int i = 0; i < LED_COUNT; i++) r_dutyActive[i] <= r_dutyShadow[i];
         end
         if (r_blinkP == 16'd0) begin
            r_phase    <= 1'b1;
            r_blinkCnt <= 16'd0;
         end else if (w_pwmWrap) begin
            if (w_blinkEnd) begin
               r_phase    <= ~r_phase;
               r_blinkCnt <= 16'd0;
            end else begin
               r_blinkCnt <= r_blinkCnt + 16'd1;
            end
         end
         for (int i = 0; i < LED_COUNT; i++) begin
            r_leds[i] <= r_data[i]
                         & (~r_ctrl[1] | (r_pwmCnt < r_dutyActive[i]))
                         & (~r_ctrl[2] | r_phase);
         end
      end
   end

endmodule

// File: tb/tb_pwm_leds_bus_interface.sv
// Self-checking bench for the LED controller with 4 LEDs and a 4-bit PWM.
// Expected values are queued when a read or a waveform measurement is set up
// and popped when the corresponding bus data or pulse width appears.
module tb_pwm_leds_bus_interface;
   localparam logic [31:0] A_CTRL   = 32'h7000_0000;
   localparam logic [31:0] A_STATUS = 32'h7000_0004;
   localparam logic [31:0] A_DATA   = 32'h7000_0008;
   localparam logic [31:0] A_BLINK  = 32'h7000_000C;
   localparam logic [31:0] A_DUTY0  = 32'h7000_0010;

   logic       clk;
   logic       rst;
   logic       ctrlEn;
   logic [3:0] ctrlLeds;

   int testsRun;
   int testsFailed;

   logic [31:0] expQ [$];
   string       tagQ [$];

   pwm_leds_bus_interface_if bus ();

   pwm_leds_bus_interface #(
      .LED_COUNT (4),
      .PWM_WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .ctrl_en   (ctrlEn),
      .ctrl_leds (ctrlLeds)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit in case a wait is ever left unbounded.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Counts a comparison and reports it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic pushExpect(input string tag, input logic [31:0] value);
      expQ.push_back(value);
      tagQ.push_back(tag);
   endtask

   task automatic popCheck(input logic [31:0] actual);
      if (expQ.size() == 0) begin
         checkOutput("sbUnderflow", 32'd0, 32'd1);
      end else begin
         string t;
         logic [31:0] e;
         t = tagQ.pop_front();
         e = expQ.pop_front();
         checkOutput(t, actual, e);
      end
   endtask

   task automatic waitRelease();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.fc_bus !== 1'b1) return;
      end
      checkOutput("releaseTimeout", 32'd0, 32'd1);
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
      bit got;
      got = 1'b0;
      bus.addr_bus      = addr;
      bus.mstData       = data;
      bus.mstOe         = 1'b1;
      bus.data_mask_bus = mask;
      bus.wr_bus        = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.fc_bus === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) checkOutput("wrTimeout", 32'd0, 32'd1);
      bus.wr_bus = 1'b0;
      bus.mstOe  = 1'b0;
      waitRelease();
   endtask

   task automatic busRead(input string tag, input logic [31:0] addr,
                          input logic [31:0] expected);
      bit got;
      got = 1'b0;
      pushExpect(tag, expected);
      bus.addr_bus = addr;
      bus.rd_bus   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.fc_bus === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (got) begin
         popCheck(bus.data_bus);
      end else begin
         checkOutput("rdTimeout", 32'd0, 32'd1);
         void'(expQ.pop_front());
         void'(tagQ.pop_front());
      end
      bus.rd_bus = 1'b0;
      waitRelease();
   endtask

   // Drives a request that must not be acknowledged and counts fc_bus pulses.
   task automatic noResponse(input string tag, input logic [31:0] addr,
                             input logic rd, input logic wr);
      int seen;
      seen = 0;
      bus.addr_bus      = addr;
      bus.mstData       = 32'hFFFF_FFFF;
      bus.mstOe         = wr;
      bus.data_mask_bus = 4'hF;
      bus.rd_bus        = rd;
      bus.wr_bus        = wr;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.fc_bus === 1'b1) seen++;
      end
      bus.rd_bus = 1'b0;
      bus.wr_bus = 1'b0;
      bus.mstOe  = 1'b0;
      checkOutput(tag, 32'(seen), 32'd0);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic countHigh(input string tag, input int cycles, input int expected);
      int n;
      n = 0;
      pushExpect(tag, 32'(expected));
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ctrlLeds[0]) n++;
      end
      popCheck(32'(n));
   endtask

   task automatic waitLevel(input logic level);
      for (int i = 0; i < 200; i++) begin
         if (ctrlLeds[0] == level) return;
         @(negedge clk);
      end
      checkOutput("levelTimeout", 32'd0, 32'd1);
   endtask

   // Length of the run at 'level' that is in progress at the current negedge.
   task automatic runLength(input logic level, output int n);
      n = 1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ctrlLeds[0] == level) n++;
         else return;
      end
   endtask

   initial begin
      int n;
      testsRun          = 0;
      testsFailed       = 0;
      rst               = 1'b1;
      bus.addr_bus      = 32'd0;
      bus.rd_bus        = 1'b0;
      bus.wr_bus        = 1'b0;
      bus.data_mask_bus = 4'h0;
      bus.mstData       = 32'd0;
      bus.mstOe         = 1'b0;

      #1;
      checkOutput("rstCtrlEn", 32'(ctrlEn), 32'd0);
      checkOutput("rstLeds", 32'(ctrlLeds), 32'd0);
      checkOutput("rstFc", 32'(bus.fc_bus === 1'b1), 32'd0);
      applyStimulus(3);
      rst = 1'b0;
      applyStimulus(1);

      busRead("rstCtrlReg", A_CTRL, 32'h0);
      busRead("rstStatus", A_STATUS, 32'h2);
      busRead("rstData", A_DATA, 32'h0);

      busWrite(A_CTRL, 32'h1, 4'hF);
      checkOutput("ctrlEnOn", 32'(ctrlEn), 32'd1);
      busWrite(A_DATA, 32'hA, 4'hF);
      applyStimulus(2);
      checkOutput("ledsA", 32'(ctrlLeds), 32'hA);
      busRead("statusEn", A_STATUS, 32'h3);

      busWrite(A_DATA, 32'hFFFF_FFFF, 4'b0000);
      busRead("maskNone", A_DATA, 32'hA);
      busWrite(A_DATA, 32'h5, 4'b0001);
      busRead("maskLane0", A_DATA, 32'h5);
      busWrite(A_DATA, 32'hFFFF_FFF0, 4'b1110);
      busRead("maskUpper", A_DATA, 32'h5);
      busWrite(A_STATUS, 32'hFFFF_FFFF, 4'hF);
      busRead("statusRo", A_STATUS, 32'h3);

      noResponse("bothReqNoFc", A_DATA, 1'b1, 1'b1);
      busRead("bothReqNoChange", A_DATA, 32'h5);
      noResponse("dutyOutOfRange", A_DUTY0 + 32'd16, 1'b1, 1'b0);
      noResponse("misaligned", A_CTRL + 32'd1, 1'b1, 1'b0);

      busWrite(A_BLINK, 32'h0001_2345, 4'hF);
      busRead("blinkTrunc", A_BLINK, 32'h2345);
      busWrite(A_BLINK, 32'h0, 4'hF);
      busWrite(A_DUTY0 + 32'd4, 32'hFF, 4'hF);
      busRead("duty1Trunc", A_DUTY0 + 32'd4, 32'hF);
      busWrite(A_DUTY0 + 32'd12, 32'h9, 4'hF);
      busRead("duty3", A_DUTY0 + 32'd12, 32'h9);

      busWrite(A_CTRL, 32'h0, 4'hF);
      busWrite(A_DATA, 32'h1, 4'hF);
      busWrite(A_DUTY0, 32'h5, 4'hF);
      busWrite(A_CTRL, 32'h3, 4'hF);
      applyStimulus(20);
      countHigh("pwmDuty5", 16, 5);
      countHigh("pwmDuty5b", 32, 10);
      busWrite(A_DUTY0, 32'h0, 4'hF);
      applyStimulus(20);
      countHigh("pwmDuty0", 32, 0);
      busWrite(A_DUTY0, 32'hF, 4'hF);
      applyStimulus(20);
      countHigh("pwmDuty15", 16, 15);
      busWrite(A_DUTY0, 32'h5, 4'hF);
      applyStimulus(20);

      pushExpect("pulseCurrent", 32'd5);
      pushExpect("pulseNext", 32'd12);
      pushExpect("pulseAfter", 32'd12);
      waitLevel(1'b0);
      waitLevel(1'b1);
      fork
         begin
            int w;
            runLength(1'b1, w);
            popCheck(32'(w));
            waitLevel(1'b1);
            runLength(1'b1, w);
            popCheck(32'(w));
            waitLevel(1'b1);
            runLength(1'b1, w);
            popCheck(32'(w));
         end
         busWrite(A_DUTY0, 32'hC, 4'hF);
      join

      busWrite(A_CTRL, 32'h0, 4'hF);
      applyStimulus(1);
      checkOutput("enOffLeds", 32'(ctrlLeds), 32'd0);
      busRead("enOffStatus", A_STATUS, 32'h2);

      busWrite(A_BLINK, 32'h2, 4'hF);
      busWrite(A_CTRL, 32'h5, 4'hF);
      pushExpect("blinkLow1", 32'd32);
      pushExpect("blinkHigh", 32'd32);
      pushExpect("blinkLow2", 32'd32);
      waitLevel(1'b0);
      runLength(1'b0, n);
      popCheck(32'(n));
      runLength(1'b1, n);
      popCheck(32'(n));
      runLength(1'b0, n);
      popCheck(32'(n));

      busWrite(A_CTRL, 32'h1, 4'hF);
      applyStimulus(2);
      checkOutput("preRstLeds", 32'(ctrlLeds), 32'h1);
      bus.addr_bus = A_DATA;
      bus.rd_bus   = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.fc_bus === 1'b1) begin
            n = 1;
            break;
         end
      end
      checkOutput("rdAckBeforeRst", 32'(n), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstFc", 32'(bus.fc_bus === 1'b1), 32'd0);
      checkOutput("midRstDataOe", 32'(bus.slvDataOe), 32'd0);
      checkOutput("midRstCtrlEn", 32'(ctrlEn), 32'd0);
      checkOutput("midRstLeds", 32'(ctrlLeds), 32'd0);
      bus.rd_bus = 1'b0;
      applyStimulus(2);
      rst = 1'b0;
      applyStimulus(1);
      busRead("postRstData", A_DATA, 32'h0);
      busWrite(A_DATA, 32'h3, 4'hF);
      busWrite(A_CTRL, 32'h1, 4'hF);
      applyStimulus(2);
      checkOutput("postRstLeds", 32'(ctrlLeds), 32'h3);
      busRead("postRstCtrl", A_CTRL, 32'h1);

      checkOutput("sbLeftover", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/pwm_leds_bus_interface.md
# pwm_leds_bus_interface

Memory-mapped LED controller for a configurable number of LED channels, sitting on the system bus as a slave device. It adds per-channel PWM brightness with glitch-free (period-aligned) duty updates and a global blink mode on top of plain on/off control. Bus side uses the standard `addr_bus`/`data_bus`/`rd_bus`/`wr_bus`/`data_mask_bus`/`fc_bus` handshake; device side drives `ctrl_en` and one line per LED.

## Interface
- `LED_COUNT`, 8: number of LED channels, 1..32.
- `PWM_WIDTH`, 8: PWM counter/duty width, 2..16.
- `CTRL_REG_ADDR`, 32'h70000000: bit0 EN, bit1 PWM_MODE, bit2 BLINK_MODE.
- `STATUS_REG_ADDR`, 32'h70000004: read-only; bit0 EN, bit1 blink phase, others 0.
- `DATA_REG_ADDR`, 32'h70000008: bits[LED_COUNT-1:0] on/off per LED.
- `BLINK_REG_ADDR`, 32'h7000000C: bits[15:0] blink half-period P, in PWM periods.
- `DUTY_REG_BASE`, 32'h70000010: duty of LED i at `DUTY_REG_BASE + 4*i`, bits[PWM_WIDTH-1:0].
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `addr_bus` in 32: byte address.
- `data_bus` inout 32: write data in; read data driven only while acknowledging a read, else high-Z.
- `rd_bus` in 1: read request.
- `wr_bus` in 1: write request.
- `data_mask_bus` in 4: write byte-lane enables, bit n = byte n.
- `fc_bus` out 1: function complete; 1 while acknowledging, else high-Z.
- `ctrl_en` out 1: CTRL.EN.
- `ctrl_leds` out LED_COUNT: LED drive, registered.

## Operation
- Hit = `addr_bus` equals any of the register addresses above (duty only for i < LED_COUNT).
- Bus FSM, states IDLE, ACK:
  - IDLE: on hit with exactly one of `rd_bus`/`wr_bus`: write updates the register with byte-lane masking (bits outside the register width ignored) or read latches the register value zero-extended; -> ACK. Both asserted, or no hit: stay IDLE, no response.
  - ACK: `fc_bus`=1; on read, drive latched data on `data_bus`. Stay while request held; -> IDLE when `rd_bus` and `wr_bus` both low. Each request performs exactly one access.
- Writes to STATUS are acknowledged and discarded; reads of any register return its current value.
- PWM counter `pwm_cnt` (PWM_WIDTH bits): increments every cycle while EN; wraps at 2^PWM_WIDTH-1 -> 0. EN=0: held at 0.
- Duty shadowing: each written duty goes to a shadow register; active duty loads from shadow on the cycle `pwm_cnt` wraps, and continuously while EN=0.
- Blink: counter counts PWM wraps; at a wrap with count == P-1, toggle phase and clear count. P=0: phase forced 1. EN=0: phase=1, count=0.
- `ctrl_leds[i]` next = EN & DATA[i] & (PWM_MODE ? `pwm_cnt` < active_duty[i] : 1) & (BLINK_MODE ? phase : 1). Duty 0 = always off; duty max = on 2^W-1 of 2^W cycles.

## Timing
- Reset (async): all registers, counters, `ctrl_en`, `ctrl_leds` = 0; blink phase = 1; FSM IDLE; `fc_bus` and `data_bus` high-Z immediately. Reset mid-transaction aborts it; no write retained beyond what already committed.
- Access accepted on edge k (IDLE, valid request): register updated and `fc_bus`=1 after edge k; `ctrl_en` follows CTRL after edge k; `ctrl_leds` reflects the new value after edge k+1.
- `fc_bus`/`data_bus` release one edge after request deassertion observed.
- Duty write mid-period takes effect at the next wrap, never mid-period.
- Clearing EN: `ctrl_leds` = 0 after next edge; counters clear same edge.

## Test plan
- Reset then write CTRL=0x1, DATA=0xA (LED_COUNT=4) -> `ctrl_en`=1, `ctrl_leds`=4'b1010; read STATUS -> 0x3.
- Write DATA=0xFFFFFFFF with `data_mask_bus`=4'b0000 -> DATA unchanged; both `rd_bus`&`wr_bus` high -> no `fc_bus`, no change.
- PWM_WIDTH=4, CTRL=0x3, DATA=0x1, duty0=5 -> `ctrl_leds[0]` high exactly 5 of every 16 cycles; duty0=0 -> never high; duty0=15 -> 15 of 16.
- Write duty0=12 mid-period while 5 active -> current period still 5 high cycles, next period 12.
- CTRL=0x5, BLINK P=2, PWM_WIDTH=4, DATA=0x1 -> `ctrl_leds[0]` high 32 cycles, low 32 cycles, repeating.
- Assert `rst` while in ACK of a read -> `fc_bus`, `data_bus` high-Z at once; all outputs 0; next write works normally.
